// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared helpers, error kinds and check-message text for param_fifo
package fifo_pkg;

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {ERR_NONE, ERR_OVF, ERR_UDF} fifo_err_e;

  localparam string MSG_OVF = "push while full without pop";
  localparam string MSG_UDF = "pop while empty";
  localparam string MSG_CNT = "occupancy exceeds DEPTH";

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - WIDTH x DEPTH register array, one write port, one registered read port
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PW    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [PW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [PW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised synchronous FIFO with thresholds and sticky error flags
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [count_w(DEPTH)-1:0]    fifo_count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clr_err
);

  localparam int CW = count_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          push_ok, pop_ok;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (32'(count_q) >= AF_LEVEL);
  assign almost_empty = (32'(count_q) <= AE_LEVEL);
  assign fifo_count   = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  always_comb begin
    push_ok  = push && (!full || pop);
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    // A new error in the same cycle as clr_err keeps the flag set.
    ovf_d = (push && full && !pop) || (ovf_q && !clr_err);
    udf_d = (pop && empty) || (udf_q && !clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;

      assume (!(push && full && !pop))
        else $warning("%m @%0t count=%0d: %s", $time, count_q, MSG_OVF);
      assert (count_q <= CW'(DEPTH))
        else $warning("%m @%0t count=%0d: %s", $time, count_q, MSG_CNT);
      assert (!(pop && empty))
        else $warning("%m @%0t count=%0d: %s", $time, count_q, MSG_UDF);
      cover (push && almost_full);
      cover (push && pop && full);
      cover (push_ok && (wr_ptr_q == PW'(DEPTH - 1)));
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (push_ok && !rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (push_data),
    .re_i    (pop_ok && !rst),
    .raddr_i (rd_ptr_q),
    .rdata_o (pop_data)
  );

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - self-checking bench for param_fifo at DEPTH 8 and DEPTH 5
module tb_param_fifo;
  import fifo_pkg::*;

  localparam int D0 = 8;
  localparam int D1 = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       push [2];
  logic       pop  [2];
  logic       clr  [2];
  logic [7:0] pd   [2];

  logic [7:0] popd0, popd1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0] cnt0;
  logic [2:0] cnt1;

  int n_assert = 0;
  int n_fail   = 0;

  int         dep [2] = '{D0, D1};
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] exp_pd  [2];
  bit         exp_ovf [2];
  bit         exp_udf [2];

  always #5 clk = ~clk;

  param_fifo #(.WIDTH(8), .DEPTH(D0)) dut0 (
    .clk(clk), .rst(rst), .push(push[0]), .push_data(pd[0]), .pop(pop[0]),
    .pop_data(popd0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .fifo_count(cnt0), .overflow(ovf0), .underflow(udf0),
    .clr_err(clr[0])
  );

  param_fifo #(.WIDTH(8), .DEPTH(D1)) dut1 (
    .clk(clk), .rst(rst), .push(push[1]), .push_data(pd[1]), .pop(pop[1]),
    .pop_data(popd1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .fifo_count(cnt1), .overflow(ovf1), .underflow(udf1),
    .clr_err(clr[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  task automatic check_dut(input int u, input string step);
    int n;
    fifo_err_e ko, ku;
    n  = qsize(u);
    ko = ERR_OVF;
    ku = ERR_UDF;
    if (u == 0) begin
      chk({step, " d8 count"}, 32'(cnt0), 32'(n));
      chk({step, " d8 full"}, 32'(full0), 32'(n == D0));
      chk({step, " d8 empty"}, 32'(empty0), 32'(n == 0));
      chk({step, " d8 almost_full"}, 32'(af0), 32'(n >= D0 - 1));
      chk({step, " d8 almost_empty"}, 32'(ae0), 32'(n <= 1));
      chk({step, " d8 ", ko.name()}, 32'(ovf0), 32'(exp_ovf[0]));
      chk({step, " d8 ", ku.name()}, 32'(udf0), 32'(exp_udf[0]));
      chk({step, " d8 pop_data"}, 32'(popd0), 32'(exp_pd[0]));
    end else begin
      chk({step, " d5 count"}, 32'(cnt1), 32'(n));
      chk({step, " d5 full"}, 32'(full1), 32'(n == D1));
      chk({step, " d5 empty"}, 32'(empty1), 32'(n == 0));
      chk({step, " d5 almost_full"}, 32'(af1), 32'(n >= D1 - 1));
      chk({step, " d5 almost_empty"}, 32'(ae1), 32'(n <= 1));
      chk({step, " d5 ", ko.name()}, 32'(ovf1), 32'(exp_ovf[1]));
      chk({step, " d5 ", ku.name()}, 32'(udf1), 32'(exp_udf[1]));
      chk({step, " d5 pop_data"}, 32'(popd1), 32'(exp_pd[1]));
    end
  endtask

  // Reference behaviour: a plain queue, popping before pushing within one cycle.
  task automatic step(input int u, input bit ps, input logic [7:0] d,
                      input bit pp, input bit c, input string tag);
    int n;
    bit f, e, pa, wa;
    n  = qsize(u);
    f  = (n == dep[u]);
    e  = (n == 0);
    pa = pp && !e;
    wa = ps && (!f || pp);
    if (pa) exp_pd[u] = (u == 0) ? q0.pop_front() : q1.pop_front();
    if (wa) begin
      if (u == 0) q0.push_back(d);
      else        q1.push_back(d);
    end
    exp_ovf[u] = (ps && f && !pp) || (exp_ovf[u] && !c);
    exp_udf[u] = (pp && e) || (exp_udf[u] && !c);
    push[u] = ps; pd[u] = d; pop[u] = pp; clr[u] = c;
    @(posedge clk);
    #1;
    push[u] = 1'b0; pop[u] = 1'b0; clr[u] = 1'b0;
    check_dut(u, tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      push[u] = 1'b0; pop[u] = 1'b0; clr[u] = 1'b0; pd[u] = 8'h00;
      exp_pd[u] = 8'h00; exp_ovf[u] = 1'b0; exp_udf[u] = 1'b0;
    end
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_dut(0, tag);
    check_dut(1, tag);
  endtask

  initial begin
    logic [7:0] r;
    do_reset("reset");

    for (int i = 1; i <= 8; i++) step(0, 1, 8'(i), 0, 0, "fill");
    chk("fill full", 32'(full0), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 8'h00, 1, 0, "drain");
      chk("drain order", 32'(popd0), 32'(i));
    end

    for (int i = 1; i <= 8; i++) step(0, 1, 8'(i), 0, 0, "fill2");
    step(0, 1, 8'hAA, 0, 0, "overflow");
    chk("overflow flag", 32'(ovf0), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 8'h00, 1, 0, "drain2");
      chk("drain2 order", 32'(popd0), 32'(i));
    end
    step(0, 0, 8'h00, 0, 1, "clr_ovf");
    chk("overflow cleared", 32'(ovf0), 32'd0);

    for (int i = 1; i <= 8; i++) step(0, 1, 8'(i), 0, 0, "fill3");
    step(0, 1, 8'h55, 1, 0, "full push+pop");
    chk("full push+pop data", 32'(popd0), 32'h01);
    chk("full push+pop count", 32'(cnt0), 32'd8);
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1, 0, "drain3");
    chk("last word", 32'(popd0), 32'h55);

    step(0, 1, 8'h33, 1, 0, "empty push+pop");
    chk("empty push+pop udf", 32'(udf0), 32'd1);
    chk("empty push+pop count", 32'(cnt0), 32'd1);
    step(0, 0, 8'h00, 1, 0, "pop 33");
    chk("pop 33", 32'(popd0), 32'h33);
    step(0, 0, 8'h00, 1, 1, "udf set+clr");
    chk("udf set wins", 32'(udf0), 32'd1);
    step(0, 0, 8'h00, 0, 1, "clr_udf");

    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 3; i++) step(u, 1, 8'($urandom), 0, 0, "prime");
      for (int i = 0; i < 20; i++) step(u, 1, 8'($urandom), 1, 0, "wrap");
      chk("wrap count", 32'(qsize(u)), 32'd3);
      for (int i = 0; i < 3; i++) step(u, 0, 8'h00, 1, 0, "wrap drain");
    end

    for (int i = 0; i < 150; i++) begin
      for (int u = 0; u < 2; u++) begin
        r = 8'($urandom);
        step(u, r[0] | r[1], 8'($urandom), r[2] & (qsize(u) != 0 || r[3]),
             ($urandom_range(0, 15) == 0), "random");
      end
    end

    do_reset("reset2");
    for (int i = 0; i < 5; i++) step(0, 1, 8'(i + 9), 0, 0, "pre-reset");
    chk("pre-reset count", 32'(cnt0), 32'd5);
    do_reset("mid reset");
    chk("mid reset empty", 32'(empty0), 32'd1);
    step(0, 1, 8'h77, 0, 0, "push 77");
    step(0, 0, 8'h00, 1, 0, "pop 77");
    chk("pop 77", 32'(popd0), 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
